// File: rtl/fbuf_pkg.sv
// Shared constants and types for the feature-buffer port responder.
// The stage record is sized by FBUF_DATA_W / FBUF_ADDR_W, so the top must keep those widths.
package fbuf_pkg;

    localparam int FBUF_DATA_W = 512;
    localparam int FBUF_ADDR_W = 11;
    localparam int FBUF_DEPTH  = 2048;
    localparam int FBUF_RD_LAT = 2;

    typedef logic [FBUF_ADDR_W-1:0] fbuf_addr_t;
    typedef logic [FBUF_DATA_W-1:0] fbuf_word_t;

    typedef struct packed {
        logic       vld;
        logic       oor;
        fbuf_addr_t addr;
        logic       fwd_hit;
        fbuf_word_t fwd_data;
    } fbuf_rd_stage_t;

    function automatic logic fbuf_in_range(input fbuf_addr_t addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/fbuf_rd_pipe.sv
// Read-request pipeline: RD_LAT stages of valid/oor/addr, RAM data delayed to the last stage.
// FBUF_WR_FWD_EN adds a per-stage write-address compare that captures younger write data.
module fbuf_rd_pipe
    import fbuf_pkg::*;
#(
    parameter int RD_LAT = FBUF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_vld,
    input  logic                   req_oor,
    input  logic [FBUF_ADDR_W-1:0] req_addr,
`ifdef FBUF_WR_FWD_EN
    input  logic                   wr_en,
    input  logic [FBUF_ADDR_W-1:0] wr_addr,
    input  logic [FBUF_DATA_W-1:0] wr_data,
`endif
    input  logic [FBUF_DATA_W-1:0] ram_q,
    output logic                   rd_valid,
    output logic [FBUF_DATA_W-1:0] rd_data
);

    fbuf_word_t     ram_out;
    fbuf_rd_stage_t last_stage;
    logic           unused_addr;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            fbuf_rd_stage_t src;
            fbuf_rd_stage_t stg_next;
            fbuf_rd_stage_t stg_reg;

            if (gi == 0) begin : g_head
                assign src = '{vld: req_vld, oor: req_oor, addr: req_addr,
                               fwd_hit: 1'b0, fwd_data: '0};
            end else begin : g_tail
                assign src = g_stage[gi-1].stg_reg;
            end

            // A later capture overwrites an earlier one, so the youngest write wins.
            always_comb begin
                stg_next = src;
`ifdef FBUF_WR_FWD_EN
                if (src.vld && wr_en && (wr_addr == src.addr)) begin
                    stg_next.fwd_hit  = 1'b1;
                    stg_next.fwd_data = wr_data;
                end
`endif
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    stg_reg <= '0;
                end else begin
                    stg_reg <= stg_next;
                end
            end
        end

        // RAM output register already supplies one cycle; delay the rest.
        if (RD_LAT == 1) begin : g_no_dly
            assign ram_out = ram_q;
        end else begin : g_dly
            fbuf_word_t dly_reg [RD_LAT-1];
            always_ff @(posedge clk) begin
                dly_reg[0] <= ram_q;
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    dly_reg[k] <= dly_reg[k-1];
                end
            end
            assign ram_out = dly_reg[RD_LAT-2];
        end
    endgenerate

    assign last_stage  = g_stage[RD_LAT-1].stg_reg;
    assign unused_addr = ^last_stage.addr;
    assign rd_valid    = last_stage.vld;
    assign rd_data     = (last_stage.vld && !last_stage.oor)
                         ? (last_stage.fwd_hit ? last_stage.fwd_data : ram_out)
                         : '0;

endmodule

// File: rtl/fbuf_port_responder.sv
// Feature-buffer bank responder: RAM, read pipeline, sticky range error and access counters.
// Optional write-to-read forwarding is enabled by defining FBUF_WR_FWD_EN.
module fbuf_port_responder
    import fbuf_pkg::*;
#(
    parameter int DATA_W = FBUF_DATA_W,
    parameter int ADDR_W = FBUF_ADDR_W,
    parameter int DEPTH  = FBUF_DEPTH,
    parameter int RD_LAT = FBUF_RD_LAT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_avalid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              err_clr,
    output logic              addr_err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q_reg;

    logic             rd_acc, wr_acc, oor_event;
    logic             addr_err_reg, addr_err_next;
    logic [CNT_W-1:0] rd_cnt_reg, rd_cnt_next;
    logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;

    assign rd_acc    = rd_avalid &&  fbuf_in_range(rd_addr, DEPTH);
    assign wr_acc    = wr_valid  &&  fbuf_in_range(wr_addr, DEPTH);
    assign oor_event = (rd_avalid && !rd_acc) || (wr_valid && !wr_acc);

    // Read-first block RAM: the registered read sees the value before this cycle's write.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_acc) begin
            ram_q_reg <= mem[rd_addr];
        end
    end

    always_comb begin
        addr_err_next = addr_err_reg;
        if (oor_event) begin
            addr_err_next = 1'b1;
        end else if (err_clr) begin
            addr_err_next = 1'b0;
        end
        rd_cnt_next = rd_cnt_reg;
        if (rd_acc && (rd_cnt_reg != '1)) begin
            rd_cnt_next = rd_cnt_reg + CNT_W'(1);
        end
        wr_cnt_next = wr_cnt_reg;
        if (wr_acc && (wr_cnt_reg != '1)) begin
            wr_cnt_next = wr_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_err_reg <= 1'b0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
        end else begin
            addr_err_reg <= addr_err_next;
            rd_cnt_reg   <= rd_cnt_next;
            wr_cnt_reg   <= wr_cnt_next;
        end
    end

    fbuf_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .req_vld  (rd_avalid),
        .req_oor  (!rd_acc),
        .req_addr (rd_addr),
`ifdef FBUF_WR_FWD_EN
        .wr_en    (wr_acc),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`endif
        .ram_q    (ram_q_reg),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    assign addr_err = addr_err_reg;
    assign rd_cnt   = rd_cnt_reg;
    assign wr_cnt   = wr_cnt_reg;

endmodule

// File: tb/tb_fbuf_port_responder.sv
// Directed bench for fbuf_port_responder (DEPTH=2000, CNT_W=4); expectations follow FBUF_WR_FWD_EN.
module tb_fbuf_port_responder;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 4;
    localparam logic [DATA_W-1:0] PAT_A5 = {64{8'hA5}};

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              rd_avalid = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              err_clr = 1'b0;
    logic              addr_err;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fbuf_port_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (2000),
        .RD_LAT (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rd_avalid (rd_avalid),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_clr   (err_clr),
        .addr_err  (addr_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_avalid = 1'b0;
        wr_valid  = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        idle();
    endtask

    // Read issued now; returns after the data cycle with outputs sampled.
    task automatic read_word(input logic [ADDR_W-1:0] a, input string tag, input logic [DATA_W-1:0] exp);
        rd_avalid = 1'b1;
        rd_addr   = a;
        tick();
        idle();
        tick();
        check({tag, "_valid"}, DATA_W'(rd_valid), DATA_W'(1));
        check({tag, "_data"}, rd_data, exp);
    endtask

    logic [DATA_W-1:0] exp_same, exp_later;

    initial begin
`ifdef FBUF_WR_FWD_EN
        exp_same  = DATA_W'(1);
        exp_later = DATA_W'(2);
`else
        exp_same  = DATA_W'(9);
        exp_later = DATA_W'(1);
`endif
        // Reset state
        tick();
        tick();
        rstn = 1'b1;
        check("rst_rd_valid", DATA_W'(rd_valid), '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_addr_err", DATA_W'(addr_err), '0);
        check("rst_rd_cnt", DATA_W'(rd_cnt), '0);
        check("rst_wr_cnt", DATA_W'(wr_cnt), '0);

        // 1: write then read two cycles later
        write_word(11'd5, PAT_A5);
        tick();
        rd_avalid = 1'b1;
        rd_addr   = 11'd5;
        tick();
        idle();
        check("t1_lat1_valid", DATA_W'(rd_valid), '0);
        tick();
        check("t1_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("t1_data", rd_data, PAT_A5);
        check("t1_rd_cnt", DATA_W'(rd_cnt), DATA_W'(1));
        check("t1_wr_cnt", DATA_W'(wr_cnt), DATA_W'(1));
        tick();
        check("t1_after_valid", DATA_W'(rd_valid), '0);
        check("t1_after_data", rd_data, '0);

        // 2: back-to-back reads of 0..3
        for (int k = 0; k < 4; k++) begin
            write_word(ADDR_W'(k), DATA_W'(k));
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                rd_avalid = 1'b1;
                rd_addr   = ADDR_W'(c);
            end else begin
                idle();
            end
            tick();
            check($sformatf("t2_c%0d_valid", c), DATA_W'(rd_valid),
                  DATA_W'((c >= 1 && c <= 4) ? 1 : 0));
            check($sformatf("t2_c%0d_data", c), rd_data,
                  (c >= 1 && c <= 4) ? DATA_W'(c - 1) : '0);
        end

        // 3: same-cycle read/write, then write one cycle after the read
        write_word(11'd7, DATA_W'(9));
        tick();
        rd_avalid = 1'b1;
        rd_addr   = 11'd7;
        wr_valid  = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = DATA_W'(1);
        tick();
        idle();
        tick();
        check("t3_same_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("t3_same_data", rd_data, exp_same);
        rd_avalid = 1'b1;
        rd_addr   = 11'd7;
        tick();
        idle();
        wr_valid  = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = DATA_W'(2);
        tick();
        idle();
        check("t3_later_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("t3_later_data", rd_data, exp_later);
        check("t3_rd_cnt", DATA_W'(rd_cnt), DATA_W'(7));
        check("t3_wr_cnt", DATA_W'(wr_cnt), DATA_W'(8));

        // 4: out-of-range accesses with DEPTH=2000
        rd_avalid = 1'b1;
        rd_addr   = 11'd2047;
        wr_valid  = 1'b1;
        wr_addr   = 11'd2001;
        wr_data   = '1;
        tick();
        idle();
        check("t4_addr_err", DATA_W'(addr_err), DATA_W'(1));
        check("t4_rd_cnt", DATA_W'(rd_cnt), DATA_W'(7));
        check("t4_wr_cnt", DATA_W'(wr_cnt), DATA_W'(8));
        tick();
        check("t4_oor_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("t4_oor_data", rd_data, '0);
        err_clr = 1'b1;
        tick();
        idle();
        check("t4_clr", DATA_W'(addr_err), '0);
        err_clr  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 11'd2001;
        tick();
        idle();
        check("t4_set_wins", DATA_W'(addr_err), DATA_W'(1));
        err_clr = 1'b1;
        tick();
        idle();
        check("t4_clr2", DATA_W'(addr_err), '0);
        rd_avalid = 1'b1;
        rd_addr   = 11'd1999;
        tick();
        idle();
        check("t4_last_in_range_err", DATA_W'(addr_err), '0);
        check("t4_last_in_range_cnt", DATA_W'(rd_cnt), DATA_W'(8));
        tick();
        rd_avalid = 1'b1;
        rd_addr   = 11'd2000;
        tick();
        idle();
        check("t4_depth_err", DATA_W'(addr_err), DATA_W'(1));
        check("t4_depth_cnt", DATA_W'(rd_cnt), DATA_W'(8));
        tick();
        check("t4_depth_data", rd_data, '0);
        read_word(11'd7, "t4_mem_kept", DATA_W'(2));
        read_word(11'd3, "t4_mem3", DATA_W'(3));

        // 5: reset with reads in flight
        rd_avalid = 1'b1;
        rd_addr   = 11'd3;
        tick();
        rd_addr   = 11'd5;
        rstn      = 1'b0;
        tick();
        rstn = 1'b1;
        idle();
        check("t5_rd_valid", DATA_W'(rd_valid), '0);
        check("t5_rd_data", rd_data, '0);
        check("t5_addr_err", DATA_W'(addr_err), '0);
        check("t5_rd_cnt", DATA_W'(rd_cnt), '0);
        check("t5_wr_cnt", DATA_W'(wr_cnt), '0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t5_post_c%0d_valid", c), DATA_W'(rd_valid), '0);
        end
        read_word(11'd5, "t5_kept", PAT_A5);
        check("t5_rd_cnt_after", DATA_W'(rd_cnt), DATA_W'(1));

        // 6: rd_cnt saturation (CNT_W=4)
        rd_avalid = 1'b1;
        rd_addr   = 11'd0;
        for (int c = 0; c < 14; c++) begin
            tick();
        end
        check("t6_at_max", DATA_W'(rd_cnt), DATA_W'(15));
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        check("t6_held", DATA_W'(rd_cnt), DATA_W'(15));
        idle();
        tick();
        tick();
        check("t6_wr_cnt", DATA_W'(wr_cnt), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
